rob_commit_ctrl: RTL and testbench

ROB_COMMIT_CTRL -- requirements
Module: rob_commit_ctrl

---
 rtl/rob_commit_if.sv | 39 +++
 rtl/rob_commit_ctrl.sv | 100 ++++++++++
 tb/tb_rob_commit_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/rob_commit_if.sv
// Commit-side bundle between the ROB head, the commit controller and the rename stage.
// The master side is the ROB/rename environment; the slave side is the commit controller.
interface rob_commit_if #(
  parameter int ARCH_W    = 5,
  parameter int PHYS_W    = 6,
  parameter int CNT_WIDTH = 32
);
  localparam int COMMIT_RENAME_WIDTH = 1 + ARCH_W + PHYS_W;

  logic                           rob_head_v_i;
  logic                           rob_head_done_i;
  logic                           rob_head_w_v_i;
  logic [ARCH_W-1:0]              rob_head_alloc_reg_i;
  logic [PHYS_W-1:0]              rob_head_freed_reg_i;
  logic                           rob_head_mispredict_i;
  logic                           commit_en_i;

  logic                           rob_retire_o;
  logic                           commit_v_o;
  logic [COMMIT_RENAME_WIDTH-1:0] commit_rename_o;
  logic                           mispredict_o;
  logic                           flush_o;
  logic [CNT_WIDTH-1:0]           retired_cnt_o;
  logic [CNT_WIDTH-1:0]           mispredict_cnt_o;

  modport master (
    output rob_head_v_i, rob_head_done_i, rob_head_w_v_i, rob_head_alloc_reg_i,
           rob_head_freed_reg_i, rob_head_mispredict_i, commit_en_i,
    input  rob_retire_o, commit_v_o, commit_rename_o, mispredict_o, flush_o,
           retired_cnt_o, mispredict_cnt_o
  );

  modport slave (
    input  rob_head_v_i, rob_head_done_i, rob_head_w_v_i, rob_head_alloc_reg_i,
           rob_head_freed_reg_i, rob_head_mispredict_i, commit_en_i,
    output rob_retire_o, commit_v_o, commit_rename_o, mispredict_o, flush_o,
           retired_cnt_o, mispredict_cnt_o
  );
endinterface

// File: rtl/rob_commit_ctrl.sv
// In-order single-entry commit controller: retires the ROB head, forwards the rename
// commit one cycle later, and holds a fixed-length flush after a mispredicted commit.
module rob_commit_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_WIDTH    = 32,
  parameter int NUM_ARCH_REG = 32,
  parameter int NUM_PHYS_REG = 64
) (
  input logic        clk_i,
  input logic        reset_n_i,
  rob_commit_if.slave bus
);
  localparam int ARCH_W = $clog2(NUM_ARCH_REG);
  localparam int PHYS_W = $clog2(NUM_PHYS_REG);
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  typedef struct packed {
    logic              w_v;
    logic [ARCH_W-1:0] alloc_reg;
    logic [PHYS_W-1:0] freed_reg;
  } commit_rename_t;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  state_t               state, state_next;
  logic [3:0]           flush_cnt, flush_cnt_next;
  logic                 retire;
  logic                 commit_v;
  logic                 mispredict;
  commit_rename_t       rename;
  logic [CNT_WIDTH-1:0] retired_cnt;
  logic [CNT_WIDTH-1:0] mispredict_cnt;

  assign retire = (state == RUN) & bus.rob_head_v_i & bus.rob_head_done_i & bus.commit_en_i;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= RUN;
      flush_cnt <= 4'd0;
    end else begin
      state     <= state_next;
      flush_cnt <= flush_cnt_next;
    end
  end

  // The count includes the current flush cycle, so leaving at 1 yields exactly FLUSH_CYCLES.
  always_comb begin
    state_next     = state;
    flush_cnt_next = flush_cnt;
    case (state)
      RUN: begin
        if (retire && bus.rob_head_mispredict_i) begin
          state_next     = FLUSH;
          flush_cnt_next = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        flush_cnt_next = flush_cnt - 4'd1;
        if (flush_cnt <= 4'd1) state_next = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  // Register names hold between commits; only the valid-type bits clear.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      commit_v   <= 1'b0;
      mispredict <= 1'b0;
      rename     <= '0;
    end else begin
      commit_v   <= retire;
      mispredict <= retire & bus.rob_head_mispredict_i;
      rename.w_v <= retire & bus.rob_head_w_v_i;
      if (retire) begin
        rename.alloc_reg <= bus.rob_head_alloc_reg_i;
        rename.freed_reg <= bus.rob_head_freed_reg_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      retired_cnt    <= '0;
      mispredict_cnt <= '0;
    end else if (retire) begin
      if (retired_cnt != '1) retired_cnt <= retired_cnt + CNT_WIDTH'(1);
      if (bus.rob_head_mispredict_i && (mispredict_cnt != '1))
        mispredict_cnt <= mispredict_cnt + CNT_WIDTH'(1);
    end
  end

  assign bus.rob_retire_o     = retire;
  assign bus.commit_v_o       = commit_v;
  assign bus.mispredict_o     = mispredict;
  assign bus.commit_rename_o  = rename;
  assign bus.flush_o          = (state == FLUSH);
  assign bus.retired_cnt_o    = retired_cnt;
  assign bus.mispredict_cnt_o = mispredict_cnt;
endmodule

// File: tb/tb_rob_commit_ctrl.sv
// Bench for rob_commit_ctrl: directed scenarios followed by random head traffic, all
// compared each cycle against a cycle-level behavioural model of the commit rules.
module tb_rob_commit_ctrl;
  localparam int FLUSH_CYCLES = 2;
  localparam int CNT_WIDTH    = 4;
  localparam int CNT_MAX      = (1 << CNT_WIDTH) - 1;

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  rob_commit_if #(.ARCH_W(5), .PHYS_W(6), .CNT_WIDTH(CNT_WIDTH)) bus ();

  rob_commit_ctrl #(
    .FLUSH_CYCLES(FLUSH_CYCLES),
    .CNT_WIDTH   (CNT_WIDTH),
    .NUM_ARCH_REG(32),
    .NUM_PHYS_REG(64)
  ) dut (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .bus      (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  logic       t_v, t_done, t_wv, t_mis, t_en;
  logic [4:0] t_alloc;
  logic [5:0] t_freed;

  int         m_flush_left;
  logic       m_commit_v, m_mis, m_wv;
  logic [4:0] m_alloc;
  logic [5:0] m_freed;
  int         m_ret, m_miscnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    m_flush_left = 0;
    m_commit_v = 0; m_mis = 0; m_wv = 0;
    m_alloc = '0; m_freed = '0;
    m_ret = 0; m_miscnt = 0;
  endtask

  function automatic logic modelRetire();
    return (m_flush_left == 0) && t_v && t_done && t_en;
  endfunction

  task automatic modelStep();
    logic r;
    r = modelRetire();
    m_commit_v = r;
    m_mis = r && t_mis;
    m_wv  = r && t_wv;
    if (r) begin
      m_alloc = t_alloc;
      m_freed = t_freed;
      if (m_ret < CNT_MAX) m_ret++;
      if (t_mis && m_miscnt < CNT_MAX) m_miscnt++;
    end
    if (r && t_mis) m_flush_left = FLUSH_CYCLES;
    else if (m_flush_left > 0) m_flush_left--;
  endtask

  task automatic checkOutput(input string tag);
    logic [11:0] cr;
    cr = bus.commit_rename_o;
    check({tag, ".retire"},    32'(bus.rob_retire_o),     32'(modelRetire()));
    check({tag, ".commit_v"},  32'(bus.commit_v_o),       32'(m_commit_v));
    check({tag, ".mispred"},   32'(bus.mispredict_o),     32'(m_mis));
    check({tag, ".w_v"},       32'(cr[11]),               32'(m_wv));
    check({tag, ".alloc"},     32'(cr[10:6]),             32'(m_alloc));
    check({tag, ".freed"},     32'(cr[5:0]),              32'(m_freed));
    check({tag, ".flush"},     32'(bus.flush_o),          32'(m_flush_left > 0));
    check({tag, ".ret_cnt"},   32'(bus.retired_cnt_o),    32'(m_ret));
    check({tag, ".mis_cnt"},   32'(bus.mispredict_cnt_o), 32'(m_miscnt));
  endtask

  // Called shortly after a rising edge: drive, compare at the falling edge, then advance.
  task automatic applyStimulus(input string tag, input logic v, input logic done,
                               input logic wv, input logic [4:0] alloc,
                               input logic [5:0] freed, input logic mis, input logic en);
    t_v = v; t_done = done; t_wv = wv; t_alloc = alloc; t_freed = freed; t_mis = mis; t_en = en;
    bus.rob_head_v_i          = v;
    bus.rob_head_done_i       = done;
    bus.rob_head_w_v_i        = wv;
    bus.rob_head_alloc_reg_i  = alloc;
    bus.rob_head_freed_reg_i  = freed;
    bus.rob_head_mispredict_i = mis;
    bus.commit_en_i           = en;
    @(negedge clk_i);
    checkOutput(tag);
    @(posedge clk_i);
    modelStep();
    #1;
  endtask

  task automatic doReset();
    reset_n_i = 1'b0;
    #1;
    modelReset();
    t_v = 0; t_done = 0; t_wv = 0; t_mis = 0; t_en = 0; t_alloc = '0; t_freed = '0;
    bus.rob_head_v_i = 0; bus.rob_head_done_i = 0; bus.rob_head_w_v_i = 0;
    bus.rob_head_alloc_reg_i = '0; bus.rob_head_freed_reg_i = '0;
    bus.rob_head_mispredict_i = 0; bus.commit_en_i = 0;
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    logic [4:0] base;
    doReset();
    checkOutput("reset");

    // Single plain retire
    applyStimulus("r035", 1, 1, 1, 5'd3, 6'd40, 0, 1);
    applyStimulus("r035_after", 0, 0, 0, 5'd0, 6'd0, 0, 1);
    check("r035_cnt", 32'(bus.retired_cnt_o), 32'd1);

    // Held head with a commit-enable gap in the second cycle
    applyStimulus("r036_c1", 1, 1, 1, 5'd4, 6'd11, 0, 1);
    applyStimulus("r036_c2", 1, 1, 1, 5'd5, 6'd12, 0, 0);
    applyStimulus("r036_c3", 1, 1, 0, 5'd6, 6'd13, 0, 1);
    applyStimulus("r036_c4", 1, 1, 1, 5'd7, 6'd14, 0, 1);
    applyStimulus("r036_c5", 0, 0, 0, 5'd0, 6'd0, 0, 1);
    check("r036_cnt", 32'(bus.retired_cnt_o), 32'd4);

    // Mispredicted retire followed by a held valid head
    doReset();
    applyStimulus("r037_n",  1, 1, 1, 5'd9, 6'd20, 1, 1);
    check("r037_flush_n1", 32'(bus.flush_o), 32'd1);
    applyStimulus("r037_n1", 1, 1, 1, 5'd10, 6'd21, 0, 1);
    applyStimulus("r037_n2", 1, 1, 1, 5'd10, 6'd21, 0, 0);
    applyStimulus("r037_n3", 1, 1, 1, 5'd10, 6'd21, 0, 1);
    applyStimulus("r037_n4", 0, 0, 0, 5'd0, 6'd0, 0, 1);
    check("r037_miscnt", 32'(bus.mispredict_cnt_o), 32'd1);

    // Not-done head stalls
    for (int i = 0; i < 5; i++) applyStimulus("r038", 1, 0, 1, 5'd1, 6'd1, 1, 1);
    applyStimulus("r038_v0", 0, 1, 1, 5'd1, 6'd1, 1, 1);

    // Asynchronous reset in the middle of a flush
    applyStimulus("r039_mis", 1, 1, 1, 5'd2, 6'd33, 1, 1);
    #1 reset_n_i = 1'b0;
    #1;
    check("r039_flush",    32'(bus.flush_o),          32'd0);
    check("r039_commit_v", 32'(bus.commit_v_o),       32'd0);
    check("r039_ret_cnt",  32'(bus.retired_cnt_o),    32'd0);
    check("r039_mis_cnt",  32'(bus.mispredict_cnt_o), 32'd0);
    modelReset();
    #1 reset_n_i = 1'b1;
    applyStimulus("r039_post", 1, 1, 1, 5'd8, 6'd50, 0, 1);
    applyStimulus("r039_post2", 0, 0, 0, 5'd0, 6'd0, 0, 1);
    check("r039_cnt", 32'(bus.retired_cnt_o), 32'd1);

    // Counter saturation: bring to all-ones minus one, then three more retires
    doReset();
    for (int i = 0; i < CNT_MAX - 1; i++) begin
      base = 5'(i);
      applyStimulus("r040_fill", 1, 1, 1, base, 6'(i), 0, 1);
    end
    applyStimulus("r040_chk", 0, 0, 0, 5'd0, 6'd0, 0, 1);
    check("r040_pre", 32'(bus.retired_cnt_o), 32'(CNT_MAX - 1));
    for (int i = 0; i < 3; i++) applyStimulus("r040_sat", 1, 1, 0, 5'd1, 6'd2, 0, 1);
    applyStimulus("r040_end", 0, 0, 0, 5'd0, 6'd0, 0, 1);
    check("r040_sat_cnt", 32'(bus.retired_cnt_o), 32'(CNT_MAX));

    // Random head traffic
    doReset();
    for (int i = 0; i < 400; i++) begin
      applyStimulus("rand",
                    1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                    1'($urandom), 5'($urandom), 6'($urandom),
                    1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 4) != 0));
    end

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
